// File: rtl/fns_pkg.sv
// rtl/fns_pkg.sv - shared constants and helpers for the FNS repair allocator
package fns_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_SCAN = S_SCAN,
        ST_DONE = S_DONE
    } state_t;

    // F(1) = F(2) = 1
    function automatic int fib(input int n);
        int a;
        int b;
        int t;
        a = 0;
        b = 1;
        for (int k = 1; k < n; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fns_repair_scanner_if.sv
// rtl/fns_repair_scanner_if.sv - scan request and result bundle of the repair allocator
interface fns_repair_scanner_if
    import fns_pkg::*;
#(
    parameter int N_TSV  = 9,
    parameter int N_DATA = 5,
    parameter int WGT_W  = 4
);
    localparam int CW = clog2(N_DATA + 1);

    logic                     start;
    logic [N_TSV-1:0]         f_flag;
    logic                     busy;
    logic                     done;
    logic                     ok;
    logic [N_TSV-1:0]         en_flag;
    logic [N_TSV*WGT_W-1:0]   weights;
    logic [CW-1:0]            n_en;

    modport master (
        output start, f_flag,
        input  busy, done, ok, en_flag, weights, n_en
    );

    modport slave (
        input  start, f_flag,
        output busy, done, ok, en_flag, weights, n_en
    );

endinterface

// File: rtl/fns_step.sv
// rtl/fns_step.sv - combinational single-TSV Fibonacci allocation step
module fns_step #(
    parameter int WGT_W = 4
) (
    input  logic [WGT_W-1:0] p,
    input  logic [WGT_W-1:0] q,
    input  logic             fault,
    input  logic             saturated,
    output logic             en,
    output logic [WGT_W-1:0] weight,
    output logic [WGT_W-1:0] p_next,
    output logic [WGT_W-1:0] q_next
);
    logic [WGT_W-1:0] sum;

    // sum may wrap when saturated, but it is only used when enabled
    assign sum    = p + q;
    assign en     = !fault && !saturated;
    assign weight = en ? sum : '0;
    assign p_next = en ? q : p;
    assign q_next = en ? sum : q;

endmodule

// File: rtl/fns_repair_scanner.sv
// rtl/fns_repair_scanner.sv - sequential one-TSV-per-cycle FNS repair allocator
module fns_repair_scanner
    import fns_pkg::*;
#(
    parameter int N_TSV  = 9,
    parameter int N_DATA = 5,
    parameter int WGT_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fns_repair_scanner_if.slave  bus
);
    localparam int IW = clog2(N_TSV);
    localparam int CW = clog2(N_DATA + 1);
    localparam logic [IW-1:0] I_LAST = IW'(N_TSV - 1);

    if (fib(N_DATA + 1) >= (2 ** WGT_W)) begin : g_wgt_check
        $error("WGT_W too narrow for F(N_DATA+1)");
    end
    if (N_DATA < 1 || N_DATA > N_TSV || N_TSV < 2) begin : g_cnt_check
        $error("illegal N_TSV/N_DATA combination");
    end

    state_t                 state_q, state_d;
    logic [N_TSV-1:0]       f_q, f_d;
    logic [N_TSV-1:0]       en_flag_q, en_flag_d;
    logic [N_TSV*WGT_W-1:0] weights_q, weights_d;
    logic [CW-1:0]          n_en_q, n_en_d;
    logic                   ok_q, ok_d;
    logic [IW-1:0]          i_q, i_d;
    logic [WGT_W-1:0]       p_q, p_d, q_q, q_d;

    logic                   st_en;
    logic [WGT_W-1:0]       st_weight, st_p, st_q;

    fns_step #(.WGT_W(WGT_W)) u_step (
        .p         (p_q),
        .q         (q_q),
        .fault     (f_q[i_q]),
        .saturated (n_en_q == CW'(N_DATA)),
        .en        (st_en),
        .weight    (st_weight),
        .p_next    (st_p),
        .q_next    (st_q)
    );

    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        en_flag_d = en_flag_q;
        weights_d = weights_q;
        n_en_d    = n_en_q;
        ok_d      = ok_q;
        i_d       = i_q;
        p_d       = p_q;
        q_d       = q_q;

        case (state_q)
            ST_SCAN: begin
                en_flag_d[i_q]                       = st_en;
                weights_d[int'(i_q)*WGT_W +: WGT_W]  = st_weight;
                p_d = st_p;
                q_d = st_q;
                if (st_en) begin
                    n_en_d = n_en_q + CW'(1);
                end
                if (i_q == I_LAST) begin
                    state_d = ST_DONE;
                    ok_d    = (n_en_d == CW'(N_DATA));
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // DONE also accepts so a held start restarts with no idle gap
        if (bus.start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            state_d   = ST_SCAN;
            f_d       = bus.f_flag;
            en_flag_d = '0;
            weights_d = '0;
            n_en_d    = '0;
            ok_d      = 1'b0;
            i_d       = '0;
            p_d       = '0;
            q_d       = WGT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            f_q       <= '0;
            en_flag_q <= '0;
            weights_q <= '0;
            n_en_q    <= '0;
            ok_q      <= 1'b0;
            i_q       <= '0;
            p_q       <= '0;
            q_q       <= WGT_W'(1);
        end else begin
            state_q   <= state_d;
            f_q       <= f_d;
            en_flag_q <= en_flag_d;
            weights_q <= weights_d;
            n_en_q    <= n_en_d;
            ok_q      <= ok_d;
            i_q       <= i_d;
            p_q       <= p_d;
            q_q       <= q_d;
        end
    end

    assign bus.busy    = (state_q == ST_SCAN);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.ok      = ok_q;
    assign bus.en_flag = en_flag_q;
    assign bus.weights = weights_q;
    assign bus.n_en    = n_en_q;

endmodule

// File: tb/tb_fns_repair_scanner.sv
// tb/tb_fns_repair_scanner.sv - self-checking bench for the FNS repair allocator
module tb_fns_repair_scanner;

    localparam int N_TSV  = 9;
    localparam int N_DATA = 5;
    localparam int WGT_W  = 4;
    localparam int CW     = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fns_repair_scanner_if #(.N_TSV(N_TSV), .N_DATA(N_DATA), .WGT_W(WGT_W)) bus ();

    fns_repair_scanner #(.N_TSV(N_TSV), .N_DATA(N_DATA), .WGT_W(WGT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // k-th healthy TSV (up to N_DATA) gets the k-th term of 1,2,3,5,8,...
    function automatic void model(input logic [N_TSV-1:0] flags,
                                  output logic [N_TSV-1:0] en,
                                  output logic [N_TSV*WGT_W-1:0] w,
                                  output int n, output logic okv);
        int fw[0:N_DATA+1];
        int k;
        fw[1] = 1;
        fw[2] = 2;
        for (int j = 3; j <= N_DATA; j++) fw[j] = fw[j-1] + fw[j-2];
        k  = 0;
        en = '0;
        w  = '0;
        for (int t = 0; t < N_TSV; t++) begin
            if (!flags[t] && k < N_DATA) begin
                k++;
                en[t] = 1'b1;
                w[t*WGT_W +: WGT_W] = WGT_W'(fw[k]);
            end
        end
        n   = k;
        okv = (k == N_DATA);
    endfunction

    task automatic do_scan(input logic [N_TSV-1:0] flags, output int lat, output int busy_cnt);
        @(negedge clk);
        bus.f_flag = flags;
        bus.start  = 1'b1;
        lat = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            lat++;
            if (bus.busy) busy_cnt++;
        end while (!bus.done && lat < 40);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.f_flag = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.busy, bus.done, bus.ok} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b want 000", {bus.busy, bus.done, bus.ok});
        end
        vectors++;
        if ({bus.en_flag, bus.weights, bus.n_en} !== '0) begin
            miscompares++;
            $display("FAIL reset_results got en=%h w=%h n=%0d want 0", bus.en_flag, bus.weights, bus.n_en);
        end
        rst = 1'b0;
    endtask

    task automatic test_fixed;
        logic [N_TSV-1:0]       fl   [4] = '{9'h000, 9'h005, 9'h01F, 9'h00F};
        logic [N_TSV-1:0]       en_x [4] = '{9'b000011111, 9'b001111010, 9'b111100000, 9'b111110000};
        logic [N_TSV*WGT_W-1:0] w_x  [4] = '{36'h000085321, 36'h008532010, 36'h532100000, 36'h853210000};
        int                     n_x  [4] = '{5, 5, 4, 5};
        logic                   ok_x [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        int lat, bc;
        for (int c = 0; c < 4; c++) begin
            do_scan(fl[c], lat, bc);
            vectors++;
            if (lat !== N_TSV + 1 || bc !== N_TSV) begin
                miscompares++;
                $display("FAIL fixed%0d_timing got lat=%0d busy=%0d want %0d/%0d", c, lat, bc, N_TSV + 1, N_TSV);
            end
            vectors++;
            if (bus.en_flag !== en_x[c] || bus.weights !== w_x[c]) begin
                miscompares++;
                $display("FAIL fixed%0d_alloc got en=%b w=%h want en=%b w=%h", c, bus.en_flag, bus.weights, en_x[c], w_x[c]);
            end
            vectors++;
            if (bus.n_en !== CW'(n_x[c]) || bus.ok !== ok_x[c]) begin
                miscompares++;
                $display("FAIL fixed%0d_count got n=%0d ok=%b want n=%0d ok=%b", c, bus.n_en, bus.ok, n_x[c], ok_x[c]);
            end
            @(negedge clk);
            vectors++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.en_flag !== en_x[c] || bus.ok !== ok_x[c]) begin
                miscompares++;
                $display("FAIL fixed%0d_hold got done=%b busy=%b en=%b ok=%b want 0 0 %b %b",
                         c, bus.done, bus.busy, bus.en_flag, bus.ok, en_x[c], ok_x[c]);
            end
        end
    endtask

    task automatic test_random;
        logic [N_TSV-1:0]       flags, en_m;
        logic [N_TSV*WGT_W-1:0] w_m;
        int                     n_m, lat, bc;
        logic                   ok_m;
        for (int r = 0; r < 16; r++) begin
            flags = (r % 2 == 0) ? N_TSV'($urandom) : N_TSV'($urandom & $urandom);
            model(flags, en_m, w_m, n_m, ok_m);
            do_scan(flags, lat, bc);
            vectors++;
            if (lat !== N_TSV + 1 || bus.en_flag !== en_m || bus.weights !== w_m ||
                bus.n_en !== CW'(n_m) || bus.ok !== ok_m) begin
                miscompares++;
                $display("FAIL random%0d flags=%b got lat=%0d en=%b w=%h n=%0d ok=%b want lat=%0d en=%b w=%h n=%0d ok=%b",
                         r, flags, lat, bus.en_flag, bus.weights, bus.n_en, bus.ok,
                         N_TSV + 1, en_m, w_m, n_m, ok_m);
            end
        end
    endtask

    task automatic test_midscan;
        int lat;
        @(negedge clk);
        bus.f_flag = 9'h00F;
        bus.start  = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            bus.start = (lat == 3 || lat == 6);
            if (lat >= 2) bus.f_flag = N_TSV'($urandom);
        end while (!bus.done && lat < 40);
        bus.start = 1'b0;
        vectors++;
        if (lat !== N_TSV + 1) begin
            miscompares++;
            $display("FAIL midscan_latency got %0d want %0d", lat, N_TSV + 1);
        end
        vectors++;
        if (bus.en_flag !== 9'b111110000 || bus.weights !== 36'h853210000 || bus.ok !== 1'b1) begin
            miscompares++;
            $display("FAIL midscan_result got en=%b w=%h ok=%b want 111110000 853210000 1", bus.en_flag, bus.weights, bus.ok);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midscan_no_queue got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_midscan;
        int lat, bc;
        @(negedge clk);
        bus.f_flag = 9'h000;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_busy got %b want 1", bus.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({bus.busy, bus.done, bus.ok, bus.en_flag, bus.weights, bus.n_en} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_clear got busy=%b done=%b ok=%b en=%b w=%h n=%0d want all 0",
                     bus.busy, bus.done, bus.ok, bus.en_flag, bus.weights, bus.n_en);
        end
        do_scan(9'h000, lat, bc);
        vectors++;
        if (lat !== N_TSV + 1 || bus.en_flag !== 9'h01F || bus.weights !== 36'h000085321 ||
            bus.n_en !== CW'(5) || bus.ok !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_rescan got lat=%0d en=%b w=%h n=%0d ok=%b want 10 000011111 000085321 5 1",
                     lat, bus.en_flag, bus.weights, bus.n_en, bus.ok);
        end
    endtask

    task automatic test_back_to_back;
        logic [N_TSV-1:0]       cur, en_m;
        logic [N_TSV*WGT_W-1:0] w_m;
        int                     n_m, cyc, last_done, runs;
        logic                   ok_m;
        @(negedge clk);
        cur = N_TSV'($urandom);
        bus.f_flag = cur;
        bus.start  = 1'b1;
        cyc = 0;
        last_done = -1;
        runs = 0;
        while (runs < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                vectors++;
                if (cyc - ((last_done < 0) ? 0 : last_done) !== N_TSV + 1) begin
                    miscompares++;
                    $display("FAIL b2b_period got %0d want %0d", cyc - ((last_done < 0) ? 0 : last_done), N_TSV + 1);
                end
                model(cur, en_m, w_m, n_m, ok_m);
                vectors++;
                if (bus.en_flag !== en_m || bus.weights !== w_m || bus.n_en !== CW'(n_m) || bus.ok !== ok_m) begin
                    miscompares++;
                    $display("FAIL b2b_run%0d flags=%b got en=%b w=%h n=%0d ok=%b want en=%b w=%h n=%0d ok=%b",
                             runs, cur, bus.en_flag, bus.weights, bus.n_en, bus.ok, en_m, w_m, n_m, ok_m);
                end
                last_done = cyc;
                runs++;
                cur = N_TSV'($urandom);
                bus.f_flag = cur;
            end else if (last_done >= 0 && cyc == last_done + 1) begin
                vectors++;
                if ({bus.en_flag, bus.weights, bus.n_en, bus.ok} !== '0 || bus.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_clear got en=%b w=%h n=%0d ok=%b busy=%b want 0 0 0 0 1",
                             bus.en_flag, bus.weights, bus.n_en, bus.ok, bus.busy);
                end
            end
        end
        vectors++;
        if (runs !== 3) begin
            miscompares++;
            $display("FAIL b2b_runs got %0d want 3", runs);
        end
        bus.start = 1'b0;
        repeat (N_TSV + 3) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_fixed;
        test_random;
        test_midscan;
        test_reset_midscan;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
